// File: rtl/float_to_int.sv
// Multi-cycle IEEE 754 single-precision to signed 32-bit integer converter.
// Truncates toward zero, saturates out-of-range and infinite inputs, flags NaN.
module float_to_int #(
   parameter int unsigned EXP_BIAS = 127
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        ack,
   input  logic [31:0] fl_in,
   output logic [31:0] res,
   output logic        done,
   output logic        busy,
   output logic        ovf,
   output logic        nv
);

   typedef enum logic [4:0] {
      StStart    = 5'b00001,
      StClassify = 5'b00010,
      StShift    = 5'b00100,
      StSign     = 5'b01000,
      StDone     = 5'b10000
   } state_e;

   localparam logic [7:0] Bias      = 8'(EXP_BIAS);
   localparam logic [7:0] ShiftZero = Bias + 8'd23;  // exponent where mantissa LSB has weight 1
   localparam logic [7:0] SatExp    = Bias + 8'd31;  // smallest exponent that cannot fit
   localparam logic [7:0] ExpMax    = 8'hff;

   state_e      state_q, state_d;
   logic        sign_q, sign_d;
   logic [7:0]  exp_q, exp_d;
   logic [22:0] frac_q, frac_d;
   logic [31:0] mag_q, mag_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        left_q, left_d;
   logic [31:0] res_q, res_d;
   logic        ovf_q, ovf_d;
   logic        nv_q, nv_d;

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      frac_d  = frac_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      nv_d    = nv_q;
      unique case (state_q)
         StStart: begin
            if (start) begin
               sign_d  = fl_in[31];
               exp_d   = fl_in[30:23];
               frac_d  = fl_in[22:0];
               ovf_d   = 1'b0;
               nv_d    = 1'b0;
               state_d = StClassify;
            end
         end
         StClassify: begin
            if (exp_q == ExpMax && frac_q != 23'd0) begin
               res_d   = 32'h8000_0000;
               nv_d    = 1'b1;
               state_d = StDone;
            end else if (exp_q == ExpMax || exp_q >= SatExp) begin
               // -2^31 is the one value at SatExp that is still representable
               if (sign_q && exp_q == SatExp && frac_q == 23'd0) begin
                  res_d = 32'h8000_0000;
               end else begin
                  res_d = sign_q ? 32'h8000_0000 : 32'h7fff_ffff;
                  ovf_d = 1'b1;
               end
               state_d = StDone;
            end else if (exp_q < Bias) begin
               res_d   = 32'd0;
               state_d = StDone;
            end else begin
               mag_d  = {8'd0, 1'b1, frac_q};
               left_d = exp_q > ShiftZero;
               cnt_d  = (exp_q > ShiftZero) ? (exp_q - ShiftZero) : (ShiftZero - exp_q);
               state_d = (exp_q == ShiftZero) ? StSign : StShift;
            end
         end
         StShift: begin
            mag_d = left_q ? (mag_q << 1) : (mag_q >> 1);
            if (cnt_q == 8'd1) begin
               state_d = StSign;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StSign: begin
            res_d   = sign_q ? (~mag_q + 32'd1) : mag_q;
            state_d = StDone;
         end
         StDone: begin
            if (ack) begin
               state_d = StStart;
            end
         end
         default: state_d = StStart;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StStart;
         sign_q  <= 1'b0;
         exp_q   <= 8'd0;
         frac_q  <= 23'd0;
         mag_q   <= 32'd0;
         cnt_q   <= 8'd0;
         left_q  <= 1'b0;
         res_q   <= 32'd0;
         ovf_q   <= 1'b0;
         nv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         frac_q  <= frac_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         nv_q    <= nv_d;
      end
   end

   assign res  = res_q;
   assign ovf  = ovf_q;
   assign nv   = nv_q;
   assign done = (state_q == StDone);
   assign busy = (state_q != StStart);

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int: latency, value, flag and handshake checks.
module tb_float_to_int;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ack;
   logic [31:0] fl_in;
   logic [31:0] res;
   logic        done;
   logic        busy;
   logic        ovf;
   logic        nv;

   int checks = 0;
   int failures = 0;

   float_to_int #(.EXP_BIAS(127)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .ack  (ack),
      .fl_in(fl_in),
      .res  (res),
      .done (done),
      .busy (busy),
      .ovf  (ovf),
      .nv   (nv)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Count edges after the start edge until done is seen; 0 means it never came.
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic convert(input string tag, input logic [31:0] f, input logic [31:0] exp_res,
                          input logic exp_ovf, input logic exp_nv, input int exp_lat);
      int lat;
      @(negedge clk);
      fl_in = f;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      fl_in = ~f;  // must be ignored after the latch
      check({tag, ".busy"}, 32'(busy), 32'd1);
      wait_done(lat);
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".res"}, res, exp_res);
      check({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
      check({tag, ".nv"}, 32'(nv), 32'(exp_nv));
      repeat (2) @(posedge clk);
      #1;
      check({tag, ".hold"}, {done, ovf, nv, res[28:0]}, {1'b1, exp_ovf, exp_nv, exp_res[28:0]});
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
      check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
      check({tag, ".keep"}, res, exp_res);
   endtask

   initial begin
      int lat;
      int done_edges;
      rst   = 1'b1;
      start = 1'b0;
      ack   = 1'b0;
      fl_in = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.res", res, 32'd0);
      check("reset.flags", {28'd0, done, busy, ovf, nv}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      convert("one",      32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25);
      convert("m123",     32'hC2F6_E979, 32'hFFFF_FF85, 1'b0, 1'b0, 19);
      convert("e150",     32'h4B00_0001, 32'h0080_0001, 1'b0, 1'b0, 2);
      convert("big_pos",  32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
      convert("min_int",  32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
      convert("neg_inf",  32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
      convert("nan",      32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1, 1);
      convert("half",     32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
      convert("denorm",   32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1);
      convert("pos_inf",  32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
      convert("ten",      32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 22);
      convert("left",     32'h4E80_0001, 32'h4000_0080, 1'b0, 1'b0, 9);

      // start held high through the whole conversion, then together with ack
      @(negedge clk);
      fl_in = 32'h3F80_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      fl_in = 32'h4120_0000;
      wait_done(lat);
      check("hold.lat", 32'(lat), 32'd25);
      check("hold.res", res, 32'h0000_0001);
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack   = 1'b0;
      start = 1'b0;
      check("hold.idle", {30'd0, busy, done}, 32'd0);
      done_edges = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (busy || done) done_edges++;
      end
      check("hold.norestart", 32'(done_edges), 32'd0);

      // reset in the middle of SHIFT abandons the conversion
      @(negedge clk);
      fl_in = 32'h3F80_0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("rstmid.busy", 32'(busy), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      ack   = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      ack   = 1'b0;
      check("rstmid.res", res, 32'd0);
      check("rstmid.flags", {28'd0, done, busy, ovf, nv}, 32'd0);

      convert("three",    32'h4040_0000, 32'h0000_0003, 1'b0, 1'b0, 24);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/float_to_int.md
FLOAT_TO_INT -- requirements
Module: float_to_int

Interface
REQ-001 SHALL have parameter EXP_BIAS, default 127, IEEE 754 single-precision exponent bias.
REQ-002 SHALL have one clock and a reset that is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request a conversion; sampled only in START.
REQ-006 SHALL have port ack, input, 1, result consumed; sampled only in DONE.
REQ-007 SHALL have port fl_in, input, 32, IEEE 754 single: [31] sign, [30:23] biased exponent, [22:0] fraction.
REQ-008 SHALL have port res, output, 32, two's-complement signed integer result.
REQ-009 SHALL have port done, output, 1, high exactly while in DONE.
REQ-010 SHALL have port busy, output, 1, high in every state except START.
REQ-011 SHALL have port ovf, output, 1, result saturated because the magnitude is out of range or the input is infinite.
REQ-012 SHALL have port nv, output, 1, input was NaN.

Function
REQ-013 SHALL implement one-hot states START, CLASSIFY, SHIFT, SIGN, DONE, with exactly one transition per clock edge.
REQ-014 SHALL, in START with start=1, latch sign, exponent e and mantissa {1'b1,fl_in[22:0]}, clear ovf/nv, and go to CLASSIFY; start=0 stays in START.
REQ-015 SHALL, in CLASSIFY with e=255 and fraction!=0 (NaN), set res=0x80000000, nv=1, and go to DONE.
REQ-016 SHALL, in CLASSIFY with e=255 and fraction=0 (infinity), saturate as in REQ-018.
REQ-017 SHALL, in CLASSIFY with e<EXP_BIAS (zero, denormal, |x|<1), set res=0 and go to DONE.
REQ-018 SHALL, in CLASSIFY with e>=158, set res=0x7FFFFFFF (positive) or 0x80000000 (negative) with ovf=1, then go to DONE.
REQ-019 SHALL map exactly -2^31 (fl_in=0xCF000000) to res=0x80000000 with ovf=0.
REQ-020 SHALL, in CLASSIFY with 127<=e<=157, load a 32-bit magnitude = zero-extended mantissa and shift count s=|e-150|, and go to SHIFT if s>0, else SIGN.
REQ-021 SHALL, in SHIFT, shift the magnitude one bit per cycle: left if e>150, right if e<150, discarding low bits (truncate toward zero); decrement s and go to SIGN when s reaches 1.
REQ-022 SHALL, in SIGN, write res = sign ? (~mag + 1) : mag, modulo 2^32, and go to DONE.
REQ-023 SHALL hold res, ovf, nv and done stable in DONE until ack=1, then go to START; res keeps its value until the next write.
REQ-024 SHALL, for a start sampled at edge N, assert done after edge N+2+s on the normal path and after edge N+1 on every CLASSIFY-terminated path.
REQ-025 SHALL ignore start outside START, including start held high during a conversion and start coincident with ack in DONE; a new conversion needs start high while in START.
REQ-026 SHALL ignore changes on fl_in after the START latch.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, enter START and set res=0, done=0, busy=0, ovf=0, nv=0, regardless of current state.
REQ-028 SHALL give rst priority over start and ack in the same cycle and abandon any conversion in progress without writing res.

Verification
REQ-029 SHALL check fl_in=0x3F800000 (1.0), start pulse -> res=0x00000001, ovf=0, nv=0, done after edge N+25; ack returns to START with busy=0.
REQ-030 SHALL check fl_in=0xC2F6E979 (-123.456) -> res=0xFFFFFF85, done after N+19; fl_in=0x4B000001 -> res=0x00800001, done after N+2.
REQ-031 SHALL check 0x4F000000 -> res=0x7FFFFFFF, ovf=1; 0xCF000000 -> res=0x80000000, ovf=0; 0xFF800000 -> res=0x80000000, ovf=1; each done after N+1.
REQ-032 SHALL check 0x7FC00000 -> res=0x80000000, nv=1; 0x3F000000 (0.5) -> res=0, done after N+1; 0x00000001 -> res=0.
REQ-033 SHALL check that start held high through SHIFT and DONE, with ack and start together in DONE, yields exactly one conversion, then START with no restart.
REQ-034 SHALL check that rst asserted mid-SHIFT on 1.0 gives all outputs 0 after that edge; the next start on 0x40400000 gives res=3.
